// File: rtl/sobel_stream_engine_if.sv
// Pixel-in / gradient-out stream bundle for sobel_stream_engine.
// The engine connects to the slave modport. The pixel source and the result sink connect to the master modport.
interface sobel_stream_engine_if;
  logic        i_rgb_vld;
  logic [31:0] i_rgb_data;
  logic        i_rgb_busy;
  logic        i_mode;
  logic [10:0] i_thresh;
  logic        o_grad_vld;
  logic [31:0] o_grad_data;
  logic        o_grad_busy;
  logic        o_grad_last;

  modport master (
    output i_rgb_vld, i_rgb_data, i_mode, i_thresh, o_grad_busy,
    input  i_rgb_busy, o_grad_vld, o_grad_data, o_grad_last
  );

  modport slave (
    input  i_rgb_vld, i_rgb_data, i_mode, i_thresh, o_grad_busy,
    output i_rgb_busy, o_grad_vld, o_grad_data, o_grad_last
  );
endinterface

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge detector: RGB pixels arrive in raster order.
// Each interior window produces one registered gradient magnitude or threshold result.
module sobel_stream_engine #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input logic                  i_clk,
  input logic                  i_rst,
  sobel_stream_engine_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_mode;
  logic [10:0]       r_thresh;
  logic              r_grad_vld;
  logic              r_grad_last;
  logic [31:0]       r_grad_data;
  logic [7:0]        r_lb0 [IMG_W];
  logic [7:0]        r_lb1 [IMG_W];
  logic [7:0]        r_win [3][2];

  logic              w_xfer;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_emit;
  logic [9:0]        w_sum;
  logic [7:0]        w_gray;
  logic [7:0]        w_p [3][3];
  logic signed [11:0] w_gx;
  logic signed [11:0] w_gy;
  logic signed [11:0] w_ax;
  logic signed [11:0] w_ay;
  logic [10:0]       w_mag;
  logic [31:0]       w_result;
  logic              w_unused;

  function automatic logic signed [11:0] f_x1(input logic [7:0] v);
    return $signed({4'b0000, v});
  endfunction

  function automatic logic signed [11:0] f_x2(input logic [7:0] v);
    return $signed({3'b000, v, 1'b0});
  endfunction

  assign bus.i_rgb_busy  = r_grad_vld & bus.o_grad_busy;
  assign bus.o_grad_vld  = r_grad_vld;
  assign bus.o_grad_data = r_grad_data;
  assign bus.o_grad_last = r_grad_last;

  assign w_xfer     = bus.i_rgb_vld & ~(r_grad_vld & bus.o_grad_busy);
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_emit     = w_xfer && (r_row >= RW'(2)) && (r_col >= RW'(0) + CW'(2));

  assign w_sum  = {2'b00, bus.i_rgb_data[7:0]} + {1'b0, bus.i_rgb_data[15:8], 1'b0}
                + {2'b00, bus.i_rgb_data[23:16]};
  assign w_gray = w_sum[9:2];

  // The stored window holds only the two older columns. The newest column comes straight from the line buffers and the incoming pixel.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_p[i][0] = r_win[i][0];
      w_p[i][1] = r_win[i][1];
    end
    w_p[0][2] = r_lb0[r_col];
    w_p[1][2] = r_lb1[r_col];
    w_p[2][2] = w_gray;
  end

  assign w_gx = (f_x1(w_p[0][2]) + f_x2(w_p[1][2]) + f_x1(w_p[2][2]))
              - (f_x1(w_p[0][0]) + f_x2(w_p[1][0]) + f_x1(w_p[2][0]));
  assign w_gy = (f_x1(w_p[2][0]) + f_x2(w_p[2][1]) + f_x1(w_p[2][2]))
              - (f_x1(w_p[0][0]) + f_x2(w_p[0][1]) + f_x1(w_p[0][2]));
  assign w_ax  = w_gx[11] ? -w_gx : w_gx;
  assign w_ay  = w_gy[11] ? -w_gy : w_gy;
  assign w_mag = w_ax[10:0] + w_ay[10:0];

  always_comb begin
    w_result = '0;
    if (r_mode) w_result = (w_mag >= r_thresh) ? 32'd255 : 32'd0;
    else        w_result = {21'd0, w_mag};
  end

  assign w_unused = &{1'b0, bus.i_rgb_data[31:24], w_ax[11], w_ay[11]};

  // Mode and threshold are latched on the first pixel of each frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= 1'b0;
      r_thresh <= '0;
    end else if (w_xfer) begin
      if (r_row == '0 && r_col == '0) begin
        r_mode   <= bus.i_mode;
        r_thresh <= bus.i_thresh;
      end
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= w_gray;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= w_p[i][2];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grad_vld  <= 1'b0;
      r_grad_data <= '0;
      r_grad_last <= 1'b0;
    end else if (w_emit) begin
      r_grad_vld  <= 1'b1;
      r_grad_data <= w_result;
      r_grad_last <= w_row_last && w_col_last;
    end else if (r_grad_vld && !bus.o_grad_busy) begin
      r_grad_vld  <= 1'b0;
    end
  end

endmodule

// File: doc/sobel_stream_engine.md
SOBEL_STREAM_ENGINE -- requirements
Module: sobel_stream_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 256: pixels per row, at least 3.
REQ-002 SHALL have parameter IMG_H, default 256: rows per frame, at least 3.
REQ-003 SHALL have i_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have i_rgb_vld, input, 1 bit: the input pixel is valid.
REQ-006 SHALL have i_rgb_data, input, 32 bits: [7:0] R, [15:8] G, [23:16] B, [31:24] ignored.
REQ-007 SHALL have i_rgb_busy, output, 1 bit: the engine cannot accept a pixel.
REQ-008 SHALL have i_mode, input, 1 bit: 0 means raw magnitude, 1 means threshold.
REQ-009 SHALL have i_thresh, input, 11 bits: threshold for mode 1.
REQ-010 SHALL have o_grad_vld, output, 1 bit: the result is valid.
REQ-011 SHALL have o_grad_data, output, 32 bits: the result word.
REQ-012 SHALL have o_grad_busy, input, 1 bit: downstream cannot accept a result.
REQ-013 SHALL have o_grad_last, output, 1 bit: marks the final result of the frame; qualified by o_grad_vld.

Function
REQ-014 SHALL treat an input transfer as i_rgb_vld=1 and i_rgb_busy=0 at a rising edge, and an output transfer as o_grad_vld=1 and o_grad_busy=0.
REQ-015 SHALL drive i_rgb_busy = o_grad_vld AND o_grad_busy, combinationally; if the output is taken in a cycle, a new pixel SHALL be accepted in that same cycle, giving one pixel per cycle at full throughput.
REQ-016 SHALL compute gray = (R + 2G + B) >> 2 at 8 bits.
REQ-017 SHALL take pixels in raster order and track column c (0..IMG_W-1) and row r (0..IMG_H-1).
- On each input transfer, c increments.
- At c=IMG_W-1, c wraps to 0 and r increments.
- At r=IMG_H-1, c=IMG_W-1, both wrap to 0 and the next frame starts with no idle cycle.
REQ-018 SHALL keep two line buffers of IMG_W x 8 bits and a 3x3 window p[i][j], where i=0 is the oldest row and j=2 is the newest column; each transfer shifts the window by one column.
REQ-019 SHALL evaluate the window on the transfer of pixel (r,c) and produce a result only when r>=2 and c>=2; this gives (IMG_H-2)*(IMG_W-2) results per frame and none for border windows.
REQ-020 SHALL compute, in signed 12-bit arithmetic:
- Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
- Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
- mag = |Gx| + |Gy|, unsigned 11 bits, maximum 2040, with no saturation.
REQ-021 SHALL form the result by mode, with bits [31:11] always 0:
- mode 0: o_grad_data = mag zero-extended.
- mode 1: o_grad_data = 255 if mag >= thresh, else 0.
REQ-022 SHALL capture i_mode and i_thresh on the transfer of pixel (0,0) and hold them for the whole frame; mid-frame changes SHALL have no effect.
REQ-023 SHALL register the result: o_grad_vld rises at the edge that accepts the producing pixel, so latency is 1 cycle.
REQ-024 SHALL hold o_grad_data and o_grad_last stable while o_grad_vld=1 and o_grad_busy=1.
REQ-025 SHALL clear o_grad_vld after an output transfer unless a new result is loaded in the same edge.
REQ-026 SHALL set o_grad_last=1 only for the result produced from pixel (IMG_H-1, IMG_W-1).
REQ-027 SHALL produce correct results with uninitialised line-buffer contents; every emitted window contains only pixels from the current frame.

Reset
REQ-028 SHALL, while i_rst=1 at an edge, set o_grad_vld=0, o_grad_data=0, o_grad_last=0, r=0, c=0, the captured mode to 0 and the captured thresh to 0.
REQ-029 SHALL NOT require line buffers or window registers to be reset.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; the first pixel accepted after reset is pixel (0,0).
REQ-031 SHALL give i_rgb_busy=0 in the first cycle after reset.

Verification
REQ-032 Uniform frame, IMG_W=IMG_H=4, all pixels 0x00646464, mode 0 -> exactly 4 results, each 0, last flagged on the 4th.
REQ-033 Vertical edge, IMG_W=IMG_H=4, columns 0-1 = 0x000000 and columns 2-3 = 0x00FFFFFF, mode 0 -> 4 results each 1020 (Gx=1020, Gy=0).
REQ-034 Same frame with mode=1 and thresh=1000 -> results 255; rerun with thresh=1021 -> results 0; changing thresh mid-frame has no effect.
REQ-035 Backpressure: hold o_grad_busy=1 for 5 cycles while a result is pending -> o_grad_vld=1, data stable, i_rgb_busy=1, and no pixels lost or duplicated after release.
REQ-036 Reset mid-frame after 7 pixels, then send a full 4x4 frame -> exactly 4 correct results, with o_grad_last on the 4th.
REQ-037 Two back-to-back frames at full rate with o_grad_busy=0 -> 8 results, one per cycle once streaming, with o_grad_last on results 4 and 8.
